// File: rtl/riscv_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  localparam int unsigned ARB_ADDR_W         = 32;
  localparam int unsigned ARB_DATA_W         = 32;
  localparam int unsigned ARB_TIMEOUT_CYCLES = 16;

  // Returned as read data when an access is aborted by the timeout.
  localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts consecutive busy cycles; expired is high in the last allowed busy cycle.
module arb_timeout_counter
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign expired = enable & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter of fetch and load/store ports onto one memory port.
// Optional busy timeout with abort and sticky err: define ARB_TIMEOUT_EN.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W         = ARB_ADDR_W,
  parameter int unsigned DATA_W         = ARB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              err
);

  if (TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy;
  logic              timeout_hit;

  assign busy   = (state_q != IDLE);
  assign d_gnt  = ~busy & d_req;
  assign if_gnt = ~busy & if_req & ~d_req;
  assign stall  = (if_req & ~if_gnt) | (d_req & ~d_gnt);

`ifdef ARB_TIMEOUT_EN
  localparam logic [DATA_W-1:0] ErrData = DATA_W'(ARB_ERR_DATA);

  logic err_q;

  arb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (~busy),
    .enable (busy),
    .expired(timeout_hit)
  );

  // mem_ready wins over an expiry landing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (timeout_hit && !mem_ready) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (d_req) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
        end else if (if_req) begin
          state_d    = BUSY_I;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          mem_be_d   = 4'hF;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_rdata;
        end else if (timeout_hit) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          if_rvalid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          if_rdata_d  = ErrData;
`endif
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          d_rvalid_d = 1'b1;
          // Stores complete without touching the last load data.
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
        end else if (timeout_hit) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          d_rvalid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          d_rdata_d  = ErrData;
`endif
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'h0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; response data is checked by a queue-based monitor.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .stall    (stall),
    .err      (err)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_if[$];
  logic [31:0] exp_d[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rvalid pulse must match the next expected response.
  always @(negedge clk) begin
    if (if_rvalid) begin
      if (exp_if.size() == 0) chk("if_unexpected_rvalid", 32'd1, 32'd0);
      else chk("if_rdata", if_rdata, exp_if.pop_front());
    end
    if (d_rvalid) begin
      if (exp_d.size() == 0) chk("d_unexpected_rvalid", 32'd1, 32'd0);
      else chk("d_rdata", d_rdata, exp_d.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = 4'h0; mem_ready = 1'b0; mem_rdata = '0;
    step(); step();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_rvalids", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    chk("rst_rdata", if_rdata | d_rdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    step();

    // Fetch with mem_ready in the first busy cycle: rvalid two cycles after grant.
    if_req = 1'b1; if_addr = 32'h100; #1;
    chk("f_if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("f_d_gnt", {31'd0, d_gnt}, 32'd0);
    chk("f_stall", {31'd0, stall}, 32'd0);
    exp_if.push_back(32'h0050_0093);
    step();
    if_req = 1'b0; #1;
    chk("f_mem_req", {31'd0, mem_req}, 32'd1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_we_be", {27'd0, mem_we, mem_be}, 32'h0F);
    mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
    step();
    mem_ready = 1'b0; #1;
    chk("f_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("f_mem_req_drop", {31'd0, mem_req}, 32'd0);
    step();
    chk("f_rvalid_pulse", {31'd0, if_rvalid}, 32'd0);

    // Simultaneous requests: data first, fetch stalls until the rvalid IDLE cycle.
    if_req = 1'b1; if_addr = 32'h104; d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h2000; d_be = 4'hF; #1;
    chk("p_d_gnt", {31'd0, d_gnt}, 32'd1);
    chk("p_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("p_stall0", {31'd0, stall}, 32'd1);
    exp_d.push_back(32'h1122_3344);
    step();
    d_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1122_3344; #1;
    chk("p_mem_addr", mem_addr, 32'h2000);
    chk("p_if_gnt_busy", {31'd0, if_gnt}, 32'd0);
    chk("p_stall1", {31'd0, stall}, 32'd1);
    step();
    mem_ready = 1'b0; #1;
    chk("p_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("p_if_gnt_late", {31'd0, if_gnt}, 32'd1);
    chk("p_stall2", {31'd0, stall}, 32'd0);
    exp_if.push_back(32'hAAAA_0001);
    step();
    if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hAAAA_0001; #1;
    chk("p_mem_addr_if", mem_addr, 32'h104);
    step();
    mem_ready = 1'b0; #1;
    chk("p_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    step();

    // Store: d_rdata keeps the previous load value.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hCAFE_F00D; d_be = 4'b0011; #1;
    chk("s_d_gnt", {31'd0, d_gnt}, 32'd1);
    exp_d.push_back(32'h1122_3344);
    step();
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h5555_5555; #1;
    chk("s_mem_we", {31'd0, mem_we}, 32'd1);
    chk("s_mem_be", {28'd0, mem_be}, 32'h3);
    chk("s_mem_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("s_mem_addr", mem_addr, 32'h2004);
    step();
    mem_ready = 1'b0; #1;
    chk("s_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    step();

    // Slow memory: request and address held for five busy cycles.
    if_req = 1'b1; if_addr = 32'h300; #1;
    chk("w_if_gnt", {31'd0, if_gnt}, 32'd1);
    exp_if.push_back(32'h1234_5678);
    step();
    if_req = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) begin
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
      end
      #1;
      chk("w_mem_req", {31'd0, mem_req}, 32'd1);
      chk("w_mem_addr", mem_addr, 32'h300);
      chk("w_no_rvalid", {31'd0, if_rvalid}, 32'd0);
      step();
    end
    mem_ready = 1'b0; #1;
    chk("w_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    step();
    chk("w_rvalid_pulse", {31'd0, if_rvalid}, 32'd0);

    // Reset in the second BUSY_D cycle abandons the load.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2008; d_be = 4'hF; #1;
    chk("r_d_gnt", {31'd0, d_gnt}, 32'd1);
    step();
    d_req = 1'b0;
    step();
    reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
    step();
    reset = 1'b0; #1;
    chk("r_mem_req", {31'd0, mem_req}, 32'd0);
    chk("r_mem_we", {31'd0, mem_we}, 32'd0);
    chk("r_mem_addr", mem_addr, 32'd0);
    chk("r_mem_wdata", mem_wdata, 32'd0);
    chk("r_mem_be", {28'd0, mem_be}, 32'd0);
    chk("r_rdata", if_rdata | d_rdata, 32'd0);
    chk("r_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    step();
    mem_ready = 1'b0; #1;
    chk("r_no_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    chk("r_idle_ignore", {31'd0, mem_req}, 32'd0);
    step();

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: abort after 16 busy cycles with error data.
    if_req = 1'b1; if_addr = 32'h400; #1;
    chk("t_if_gnt", {31'd0, if_gnt}, 32'd1);
    exp_if.push_back(32'hDEAD_BEEF);
    step();
    if_req = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      chk("t_mem_req", {31'd0, mem_req}, 32'd1);
      chk("t_err_low", {31'd0, err}, 32'd0);
      step();
    end
    chk("t_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("t_mem_req_drop", {31'd0, mem_req}, 32'd0);
    chk("t_err_set", {31'd0, err}, 32'd1);
    step(); step(); step();
    chk("t_err_sticky", {31'd0, err}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0; #1;
    chk("t_err_reset", {31'd0, err}, 32'd0);
`else
    chk("no_timeout_err", {31'd0, err}, 32'd0);
`endif

    step(); step();
    chk("if_queue_drain", exp_if.size(), 32'd0);
    chk("d_queue_drain", exp_d.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the busy-cycle limit before abort (used only with ARB_TIMEOUT_EN).
REQ-004 SHALL use one clock and a synchronous, active-high reset; clock and reset ports are named clk and reset.
REQ-005 SHALL have these ports, one per line:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  load/store request
- d_we  in  1  1 = store
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  4  byte enables
- d_gnt  out  1  data accepted
- d_rvalid  out  1  load data valid, or store complete
- d_rdata  out  DATA_W  load data
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  4  memory byte enables
- mem_ready  in  1  memory completes the current access
- mem_rdata  in  DATA_W  memory read data
- stall  out  1  pipeline hold
- err  out  1  sticky timeout flag

Function
REQ-006 SHALL implement a state machine with states IDLE, BUSY_I and BUSY_D.
REQ-007 In IDLE with d_req=1, SHALL assert d_gnt in the same cycle (combinational), latch d_we, d_addr, d_wdata and d_be, and enter BUSY_D; data has fixed priority over fetch.
REQ-008 In IDLE with if_req=1 and d_req=0, SHALL assert if_gnt, latch if_addr with mem_we=0 and mem_be=4'hF, and enter BUSY_I.
REQ-009 SHALL assert if_gnt and d_gnt only in IDLE, and never both in the same cycle.
REQ-010 SHALL drive mem_req=1 with registered latched values for every BUSY_x cycle, starting the cycle after the grant.
REQ-011 In BUSY_x with mem_ready=1, SHALL register mem_rdata into x_rdata, pulse x_rvalid for exactly one cycle on the next cycle, and return to IDLE; minimum latency from grant to rvalid is 2 cycles.
REQ-012 For a store, SHALL pulse d_rvalid on completion and leave d_rdata unchanged.
REQ-013 x_rdata SHALL hold its last value between transactions.
REQ-014 A requester SHALL hold its request and payload stable until granted; a request dropped before grant is withdrawn and causes no access.
REQ-015 A request present in the cycle mem_ready=1 SHALL NOT be granted until the following IDLE cycle, and the rvalid cycle is that IDLE cycle.
REQ-016 mem_ready in IDLE SHALL be ignored.
REQ-017 stall SHALL equal (if_req & ~if_gnt) | (d_req & ~d_gnt).

Reset
REQ-018 On reset, SHALL set state=IDLE and drive mem_req, mem_we, if_rvalid, d_rvalid and err to 0, and mem_addr, mem_wdata, mem_be, if_rdata and d_rdata to 0.
REQ-019 Reset mid-transaction SHALL abandon the access without rvalid; a mem_ready arriving after reset is ignored.

Configuration
REQ-020 With macro ARB_TIMEOUT_EN defined, SHALL count BUSY cycles.
REQ-021 With ARB_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without mem_ready SHALL drop mem_req, return to IDLE, pulse x_rvalid with x_rdata=32'hDEAD_BEEF, and set err sticky until reset.
REQ-022 Without ARB_TIMEOUT_EN, SHALL wait indefinitely for mem_ready, with err tied to 0 and no counter logic.

Structure
REQ-023 Package riscv_pkg SHALL hold the arb_state_t enum, ADDR_W/DATA_W defaults, the TIMEOUT_CYCLES default and the ARB_ERR_DATA constant (32'hDEAD_BEEF).
REQ-024 The timeout counter SHALL be a single sub-module, arb_timeout_counter (inputs clear and enable; output expired), instantiated only under ARB_TIMEOUT_EN.

Verification
REQ-025 Fetch if_addr=0x100, mem_ready 1 cycle after mem_req, mem_rdata=0x00500093 -> if_gnt in cycle 0, mem_req in cycle 1, if_rvalid=1 with if_rdata=0x00500093 in cycle 2.
REQ-026 if_req and d_req together, d_addr=0x2000, d_we=0 -> d_gnt first, stall=1 until if_gnt in the IDLE cycle after d_rvalid.
REQ-027 Store d_addr=0x2004, d_wdata=0xCAFEF00D, d_be=4'b0011 -> mem_we=1, mem_be=4'b0011, mem_wdata=0xCAFEF00D; d_rvalid pulses and d_rdata is unchanged.
REQ-028 mem_ready delayed 5 cycles -> mem_req stays 1 with a stable address for 5 cycles, then rvalid pulses once.
REQ-029 reset asserted in the 2nd BUSY_D cycle, then mem_ready=1 -> no d_rvalid, state=IDLE, all outputs 0.
REQ-030 With ARB_TIMEOUT_EN and mem_ready held 0 -> after 16 BUSY cycles, if_rvalid=1 with 0xDEADBEEF, err=1 and held until reset.
